// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// State encoding and the two fixed segment patterns.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder, active-low, bit0=a .. bit6=g.
// Codes above 9 decode to all segments off.
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with guard blanking,
// double-buffered digit data and leading-zero suppression.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = 4 * NUM_DIGITS;

    scan_state_t     state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   active;
    logic [DW-1:0]   pending;

    scan_state_t     nstate;
    logic [CW-1:0]   ncnt;
    logic [IW-1:0]   nidx;
    logic [DW-1:0]   nactive;
    logic            frame_start;

    logic [3:0]            code;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [6:0]            nseg;
    logic [NUM_DIGITS-1:0] nan;
    logic                  nfd;

    // Outputs are registered from next-state values so they line up
    // with the state they describe.
    always_comb begin
        nstate      = state;
        ncnt        = cnt;
        nidx        = digit_idx;
        nactive     = active;
        frame_start = 1'b0;
        if (!en) begin
            nstate = ST_IDLE;
            ncnt   = '0;
            nidx   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    nstate      = ST_BLANK;
                    ncnt        = '0;
                    nidx        = '0;
                    frame_start = 1'b1;
                end
                ST_BLANK: begin
                    ncnt = cnt + 1'b1;
                    if (cnt == CW'(GUARD - 1))
                        nstate = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (cnt == CW'(REFRESH_DIV - 1)) begin
                        nstate = ST_BLANK;
                        ncnt   = '0;
                        if (digit_idx == IW'(NUM_DIGITS - 1)) begin
                            nidx        = '0;
                            frame_start = 1'b1;
                        end else begin
                            nidx = digit_idx + 1'b1;
                        end
                    end else begin
                        ncnt = cnt + 1'b1;
                    end
                end
                default: nstate = ST_IDLE;
            endcase
        end
        if (frame_start)
            nactive = load ? digits_in : pending;
    end

    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (nactive[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above;
        end
    end

    assign code = nactive[{nidx, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd (code),
        .seg (dec_seg)
    );

    always_comb begin
        nseg = SEG_BLANK;
        nan  = '1;
        if (nstate == ST_DRIVE) begin
            nan = ~(NUM_DIGITS'(1) << nidx);
            if (blank_lz && lz_mask[nidx])
                nseg = SEG_BLANK;
            else if (code > 4'd9)
                nseg = SEG_DASH;
            else
                nseg = dec_seg;
        end
        nfd = (nstate == ST_DRIVE)
            && (ncnt == CW'(REFRESH_DIV - 1))
            && (nidx == IW'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            active     <= '0;
            pending    <= '0;
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            digit_idx  <= nidx;
            active     <= nactive;
            if (load)
                pending <= digits_in;
            seg        <= nseg;
            an         <= nan;
            frame_done <= nfd;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots).
// Frame-position reference model plus spot-check vectors.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          mt = 0;
    logic [15:0] mpend = '0;
    logic [15:0] mact = '0;
    logic [6:0]  font [10];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .GUARD      (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic step(input logic e, input logic ld,
                        input logic [15:0] d, input logic bz,
                        input logic r);
        int pos, dg, k;
        logic [3:0] xan;
        logic [6:0] xseg;
        logic [1:0] xidx;
        logic       xfd;
        logic [3:0] dv;
        en = e; load = ld; digits_in = d; blank_lz = bz; rst_n = r;
        @(posedge clk);
        if (!r) begin
            mt = 0; mpend = '0; mact = '0;
        end else begin
            if (!e) mt = 0;
            else begin
                mt++;
                if ((mt - 1) % (N * R) == 0)
                    mact = ld ? d : mpend;
            end
            if (ld) mpend = d;
        end
        xan = 4'hF; xseg = 7'h7F; xidx = 2'd0; xfd = 1'b0;
        if (r && mt != 0) begin
            pos  = (mt - 1) % (N * R);
            dg   = pos / R;
            k    = pos % R;
            xidx = 2'(dg);
            xfd  = (pos == N * R - 1);
            if (k >= G) begin
                xan = 4'hF & ~(4'(1) << dg);
                dv  = 4'((mact >> (4 * dg)) & 16'hF);
                if (bz && dg != 0 && (mact >> (4 * dg)) == 0)
                    xseg = 7'h7F;
                else if (dv > 9)
                    xseg = 7'h3F;
                else
                    xseg = font[dv];
            end
        end
        #1;
        chk($sformatf("model t=%0d", mt),
            {2'b0, an, seg, digit_idx, frame_done},
            {2'b0, xan, xseg, xidx, xfd});
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic run_to(input int e, input logic bz);
        for (int i = 0; i < 200 && mt < e; i++)
            step(1'b1, 1'b0, 16'h0, bz, 1'b1);
    endtask

    typedef struct {
        logic [15:0] val;
        logic        blz;
        int          edge_n;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t vecs [17];
    int   pulses;
    int   first_pulse;

    initial begin
        logic [6:0] hi [10];
        hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        for (int i = 0; i < 10; i++) font[i] = ~hi[i];

        vecs[0]  = '{16'h1234, 1'b0, 1,  4'b1111, 7'h7F, 1'b0};
        vecs[1]  = '{16'h1234, 1'b0, 3,  4'b1110, 7'h19, 1'b0};
        vecs[2]  = '{16'h1234, 1'b0, 8,  4'b1110, 7'h19, 1'b0};
        vecs[3]  = '{16'h1234, 1'b0, 10, 4'b1111, 7'h7F, 1'b0};
        vecs[4]  = '{16'h1234, 1'b0, 11, 4'b1101, 7'h30, 1'b0};
        vecs[5]  = '{16'h1234, 1'b0, 20, 4'b1011, 7'h24, 1'b0};
        vecs[6]  = '{16'h1234, 1'b0, 32, 4'b0111, 7'h79, 1'b1};
        vecs[7]  = '{16'h0070, 1'b1, 27, 4'b0111, 7'h7F, 1'b0};
        vecs[8]  = '{16'h0070, 1'b1, 19, 4'b1011, 7'h7F, 1'b0};
        vecs[9]  = '{16'h0070, 1'b1, 12, 4'b1101, 7'h78, 1'b0};
        vecs[10] = '{16'h0070, 1'b1, 5,  4'b1110, 7'h40, 1'b0};
        vecs[11] = '{16'h0000, 1'b1, 5,  4'b1110, 7'h40, 1'b0};
        vecs[12] = '{16'h0000, 1'b1, 13, 4'b1101, 7'h7F, 1'b0};
        vecs[13] = '{16'hFA00, 1'b0, 28, 4'b0111, 7'h3F, 1'b0};
        vecs[14] = '{16'hFA00, 1'b0, 20, 4'b1011, 7'h3F, 1'b0};
        vecs[15] = '{16'hFA00, 1'b0, 12, 4'b1101, 7'h40, 1'b0};
        vecs[16] = '{16'h0070, 1'b0, 27, 4'b0111, 7'h40, 1'b0};

        // reset state
        do_reset();
        chk("reset an", {12'h0, an}, 16'hF);
        chk("reset seg", {9'h0, seg}, 16'h7F);
        chk("reset idx", {14'h0, digit_idx}, 16'h0);
        chk("reset fd", {15'h0, frame_done}, 16'h0);

        // spot vectors, each loaded at edge 1 (bypass)
        foreach (vecs[v]) begin
            do_reset();
            step(1'b1, 1'b1, vecs[v].val, vecs[v].blz, 1'b1);
            run_to(vecs[v].edge_n, vecs[v].blz);
            chk($sformatf("vec%0d e%0d an/seg/fd", v, vecs[v].edge_n),
                {4'h0, an, seg, frame_done},
                {4'h0, vecs[v].an, vecs[v].seg, vecs[v].fd});
        end

        // frame_done pulses once per frame, at edge 32 and 64
        do_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        pulses = 0; first_pulse = 0;
        for (int i = 0; i < 200 && mt < 64; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
            if (frame_done) begin
                pulses++;
                if (first_pulse == 0) first_pulse = mt;
            end
        end
        chk("fd pulse count", 16'(pulses), 16'd2);
        chk("fd first edge", 16'(first_pulse), 16'd32);

        // mid-frame load is deferred; frame-start load bypasses
        do_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        run_to(11, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b0, 1'b1);
        run_to(13, 1'b0);
        chk("deferred load e13", {5'h0, an, seg}, {5'h0, 4'b1101, 7'h30});
        run_to(35, 1'b0);
        chk("frame2 e35", {5'h0, an, seg}, {5'h0, 4'b1110, 7'h12});
        run_to(64, 1'b0);
        step(1'b1, 1'b1, 16'h9876, 1'b0, 1'b1);
        run_to(67, 1'b0);
        chk("bypass e67", {5'h0, an, seg}, {5'h0, 4'b1110, 7'h02});
        run_to(75, 1'b0);
        chk("bypass e75", {5'h0, an, seg}, {5'h0, 4'b1101, 7'h78});

        // enable drop in DRIVE of digit 1, then restart
        do_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        run_to(13, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("en drop", {3'h0, an, seg, digit_idx}, {3'h0, 4'hF, 7'h7F, 2'd0});
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("reen blank", {5'h0, an, seg}, {5'h0, 4'hF, 7'h7F});
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("reen drive", {5'h0, an, seg}, {5'h0, 4'b1110, 7'h19});

        // synchronous reset mid-frame with en held high
        do_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1);
        run_to(19, 1'b0);
        step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
        chk("midrst", {2'h0, an, seg, digit_idx, frame_done},
            {2'h0, 4'hF, 7'h7F, 2'd0, 1'b0});
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        run_to(3, 1'b0);
        chk("post rst data", {5'h0, an, seg}, {5'h0, 4'b1110, 7'h40});

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) != 0,
                 ($urandom % 20) == 0,
                 16'($urandom),
                 1'($urandom),
                 ($urandom % 300) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It owns the single shared `bcd_to_7seg` decoder and presents one digit at a time. It walks the digit anodes and inserts a blanking guard between digits to suppress ghosting. Display data is double-buffered so updates never tear mid-frame. It sits between the BCD counter/datapath logic and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 2..8
- `REFRESH_DIV`, 1000: clock cycles per digit slot
- `GUARD`, 2: blank cycles at the start of each slot; must satisfy 1 ≤ GUARD < REFRESH_DIV
- `clk`, in, 1: single clock; all state on rising edge
- `rst_n`, in, 1: reset, synchronous, active-low
- `en`, in, 1: scan enable
- `load`, in, 1: capture `digits_in` into the pending buffer
- `digits_in`, in, 4*NUM_DIGITS: BCD digits; digit i = bits [4i+3:4i]; digit 0 = least significant
- `blank_lz`, in, 1: leading-zero blanking enable
- `seg`, out, 7: segments, active-low; bit0=a … bit6=g
- `an`, out, NUM_DIGITS: anodes, active-low, one-hot-low or all-high
- `digit_idx`, out, $clog2(NUM_DIGITS): digit currently in its slot
- `frame_done`, out, 1: one-cycle pulse at the end of each frame

## Operation
- FSM states:
  - IDLE: `an` all high, `seg`=7'h7F, counters 0.
  - BLANK: `an` all high, `seg`=7'h7F, slot counter running.
  - DRIVE: `an[digit_idx]`=0, `seg`=decoded digit.
- FSM transitions:
  - IDLE→BLANK when `en`=1.
  - BLANK→DRIVE when slot count reaches GUARD-1.
  - DRIVE→BLANK at slot count REFRESH_DIV-1, with `digit_idx` advancing and wrapping NUM_DIGITS-1→0.
  - Any state→IDLE when `en`=0.
- Buffers:
  - `load`=1 writes `digits_in` into the pending register.
  - The active register copies pending on each entry to BLANK with `digit_idx`=0, i.e. frame start and exit from IDLE.
  - If `load` coincides with frame start, `digits_in` goes straight to active (bypass).
- Decode: the active digit at `digit_idx` is fed to the shared `bcd_to_7seg`. Codes 10–15 display a dash: `seg`=7'h3F (g only).
- Leading-zero blanking (`blank_lz`=1):
  - A digit shows 7'h7F in DRIVE when it and every higher-index digit are 0.
  - Digit 0 is never blanked.
  - The anode is still pulsed, so brightness stays uniform.

## Timing
- All outputs are registered.
- Reset values: `seg`=7'h7F, `an`=all 1, `digit_idx`=0, `frame_done`=0, FSM IDLE, active=0, pending=0, slot count 0.
- Edge numbering: edge 1 is the first rising edge with `en`=1 in IDLE.
  - Edges 1..GUARD: BLANK, digit 0.
  - Edges GUARD+1..REFRESH_DIV: DRIVE, digit 0.
  - Digit d occupies edges d*REFRESH_DIV+1 .. (d+1)*REFRESH_DIV.
  - Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- `frame_done`=1 for exactly one cycle, coincident with the final DRIVE cycle of digit NUM_DIGITS-1.
- Never two anodes low in the same cycle. Never an anode low during BLANK.
- `en` drop mid-slot: the next edge gives IDLE outputs and clears counters. Re-enable restarts at digit 0 BLANK.
- `rst_n`=0 mid-frame: the next edge gives reset values regardless of `en`/`load`.
- `load` asserted mid-frame: displayed digits are unchanged until the next frame start.

## Structure
- Package `seven_seg_pkg`: FSM state encoding (IDLE/BLANK/DRIVE), constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
- Sub-module: one instance of the existing `bcd_to_7seg` (active-low outputs). Dash substitution, blanking mux and output registers live in this block.
- Slot counter width: $clog2(REFRESH_DIV).

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset then `en`=1, `load` 0x1234:
  - Edges 3–8: `an`=4'b1110, `seg`=decode(4).
  - Edges 11–16: `an`=4'b1101, `seg`=decode(3).
  - `frame_done` high only at edge 32.
  - `an`=4'hF at edges 1–2, 9–10, etc.
- `blank_lz`=1 with 0x0070: digit 3 shows 7'h7F with `an`=4'b0111. Digit 2 shows decode(0)?? no — digit 2 is also 0 above digit 1 value, so it shows 7'h7F. Digit 1 shows decode(7). Digit 0 shows decode(0). With 0x0000, only digit 0 shows decode(0).
- Invalid code 0xFA00: digits 3 and 2 show 7'h3F.
- `load` 0x5555 at edge 12 after 0x1234 was active: frame 1 still shows 1,2,3,4. Frame 2 shows all 5. Also check `load` exactly at a frame-start edge: the new value displays in that same frame (bypass).
- `en`=0 at edge 13 (DRIVE, digit 1): edge 14 gives `an`=4'hF, `seg`=7'h7F. Re-enable restarts at digit 0 with 2 blank cycles.
- `rst_n`=0 for one cycle at edge 20 with `en`=1: outputs return to reset values at that edge. Scanning restarts from digit 0 and active data is cleared to 0.
